// File: rtl/img_word_unpacker.sv
// img_word_unpacker
//
// Takes a stream of packed pixel words (LANES = WORD_W/PIX_W pixels per word) and emits
// one pixel per cycle. Each pixel is tagged with frame-position flags that come from
// row/column counters. Both sides use a valid/stall handshake: a beat transfers when
// valid is high and stall is low.
//
// Ports:
//   clock            in   rising-edge clock
//   reset            in   synchronous, active-high
//   in_data          in   packed pixel word (WORD_W)
//   in_valid         in   in_data valid
//   upstream_stall   out  word not accepted this cycle (combinational on downstream_stall)
//   out_pixel        out  current pixel (PIX_W)
//   out_valid        out  out_pixel valid
//   out_sof          out  pixel is row 0, col 0
//   out_row_last     out  pixel is col IMG_WIDTH-1
//   out_frame_last   out  pixel is row IMG_HEIGHT-1, col IMG_WIDTH-1
//   downstream_stall in   consumer cannot take the pixel this cycle
//
// Configuration:
//   IMG_UNPACK_MSB_FIRST_EN  if defined, lane 0 is the most significant pixel of the word.
//                            Otherwise (default) lane 0 is in_data[PIX_W-1:0].

module img_word_unpacker #(
    parameter int unsigned IMG_WIDTH  = 28,
    parameter int unsigned IMG_HEIGHT = 28,
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned WORD_W     = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              upstream_stall,
    output logic [PIX_W-1:0]  out_pixel,
    output logic              out_valid,
    output logic              out_sof,
    output logic              out_row_last,
    output logic              out_frame_last,
    input  logic              downstream_stall
);

    localparam int unsigned LANES  = WORD_W / PIX_W;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);

    if ((WORD_W % PIX_W) != 0 || LANES == 0) begin : g_bad_widths
        $error("WORD_W must be a non-zero multiple of PIX_W");
    end

    // State
    logic [WORD_W-1:0] wbuf_q, wbuf_d;
    logic              wbuf_valid_q, wbuf_valid_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [PIX_W-1:0]  out_pixel_q, out_pixel_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sof_q, out_sof_d;
    logic              out_row_last_q, out_row_last_d;
    logic              out_frame_last_q, out_frame_last_d;

    // Datapath / handshake
    logic              advance;
    logic              load;
    logic              accept;
    logic              final_lane;
    logic              cur_row_last;
    logic              cur_frame_last;
    logic [LANE_W-1:0] lane_sel;
    logic [WORD_W-1:0] wbuf_shifted;
    logic [PIX_W-1:0]  cur_pixel;

`ifdef IMG_UNPACK_MSB_FIRST_EN
    assign lane_sel = LAST_LANE - lane_q;
`else
    assign lane_sel = lane_q;
`endif

    assign wbuf_shifted   = wbuf_q >> (lane_sel * PIX_W);
    assign cur_pixel      = wbuf_shifted[PIX_W-1:0];

    assign cur_row_last   = (col_q == LAST_COL);
    assign cur_frame_last = cur_row_last && (row_q == LAST_ROW);

    // The output register can take a new pixel when it is empty or being drained.
    assign advance    = !out_valid_q || !downstream_stall;
    assign load       = advance && wbuf_valid_q;
    // A word is finished either at its top lane or when the frame ends mid-word,
    // in which case the remaining lanes are discarded.
    assign final_lane = (lane_q == LAST_LANE) || cur_frame_last;

    // Accepting on the edge that consumes the final lane avoids a bubble between words.
    assign upstream_stall = wbuf_valid_q && !(advance && final_lane);
    assign accept         = in_valid && !upstream_stall;

    always_comb begin
        wbuf_d           = wbuf_q;
        wbuf_valid_d     = wbuf_valid_q;
        lane_d           = lane_q;
        col_d            = col_q;
        row_d            = row_q;
        out_pixel_d      = out_pixel_q;
        out_valid_d      = out_valid_q;
        out_sof_d        = out_sof_q;
        out_row_last_d   = out_row_last_q;
        out_frame_last_d = out_frame_last_q;

        // Word buffer: a fresh word overrides the drain of the old one (same edge).
        if (accept) begin
            wbuf_d       = in_data;
            wbuf_valid_d = 1'b1;
            lane_d       = '0;
        end else if (load) begin
            if (final_lane) begin
                wbuf_valid_d = 1'b0;
            end else begin
                lane_d = lane_q + LANE_W'(1);
            end
        end

        // Output register only moves on advance; held while stalled.
        if (advance) begin
            out_valid_d      = wbuf_valid_q;
            out_sof_d        = 1'b0;
            out_row_last_d   = 1'b0;
            out_frame_last_d = 1'b0;
            if (load) begin
                out_pixel_d      = cur_pixel;
                out_sof_d        = (row_q == '0) && (col_q == '0);
                out_row_last_d   = cur_row_last;
                out_frame_last_d = cur_frame_last;

                if (cur_row_last) begin
                    col_d = '0;
                    row_d = cur_frame_last ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wbuf_q           <= '0;
            wbuf_valid_q     <= 1'b0;
            lane_q           <= '0;
            col_q            <= '0;
            row_q            <= '0;
            out_pixel_q      <= '0;
            out_valid_q      <= 1'b0;
            out_sof_q        <= 1'b0;
            out_row_last_q   <= 1'b0;
            out_frame_last_q <= 1'b0;
        end else begin
            wbuf_q           <= wbuf_d;
            wbuf_valid_q     <= wbuf_valid_d;
            lane_q           <= lane_d;
            col_q            <= col_d;
            row_q            <= row_d;
            out_pixel_q      <= out_pixel_d;
            out_valid_q      <= out_valid_d;
            out_sof_q        <= out_sof_d;
            out_row_last_q   <= out_row_last_d;
            out_frame_last_q <= out_frame_last_d;
        end
    end

    assign out_pixel      = out_pixel_q;
    assign out_valid      = out_valid_q;
    assign out_sof        = out_sof_q;
    assign out_row_last   = out_row_last_q;
    assign out_frame_last = out_frame_last_q;

endmodule

// File: tb/tb_img_word_unpacker.sv
// Bench for img_word_unpacker: instance a (28x28 default) and instance b (3x2 frame).
module tb_img_word_unpacker;

    localparam int AW = 28;
    localparam int AH = 28;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [31:0] a_in_data = '0, b_in_data = '0;
    logic        a_in_valid = 1'b0, b_in_valid = 1'b0;
    logic        a_downstream_stall = 1'b0, b_downstream_stall = 1'b0;
    logic        a_upstream_stall, b_upstream_stall;
    logic [7:0]  a_out_pixel, b_out_pixel;
    logic        a_out_valid, b_out_valid;
    logic        a_out_sof, b_out_sof;
    logic        a_out_row_last, b_out_row_last;
    logic        a_out_frame_last, b_out_frame_last;

    img_word_unpacker #(.IMG_WIDTH(AW), .IMG_HEIGHT(AH), .PIX_W(8), .WORD_W(32)) dut_a (
        .clock(clock), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid),
        .upstream_stall(a_upstream_stall), .out_pixel(a_out_pixel), .out_valid(a_out_valid),
        .out_sof(a_out_sof), .out_row_last(a_out_row_last), .out_frame_last(a_out_frame_last),
        .downstream_stall(a_downstream_stall)
    );

    img_word_unpacker #(.IMG_WIDTH(3), .IMG_HEIGHT(2), .PIX_W(8), .WORD_W(32)) dut_b (
        .clock(clock), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
        .upstream_stall(b_upstream_stall), .out_pixel(b_out_pixel), .out_valid(b_out_valid),
        .out_sof(b_out_sof), .out_row_last(b_out_row_last), .out_frame_last(b_out_frame_last),
        .downstream_stall(b_downstream_stall)
    );

    typedef struct packed {
        logic [7:0] pix;
        logic       sof;
        logic       rl;
        logic       fl;
    } exp_t;

    typedef struct {
        logic [31:0] word;
        int          n;
        logic [7:0]  pix [4];
        logic [3:0]  sof;
        logic [3:0]  rl;
        logic [3:0]  fl;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    vec_t tbl[3];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int mrow = 0, mcol = 0;

    // Burst tracking
    bit track = 1'b0;
    int prev_cyc = -1;
    int gaps = 0, xfers = 0, in_cyc = 0, stall_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] lane_pix(input logic [31:0] w, input int i);
        logic [31:0] s;
`ifdef IMG_UNPACK_MSB_FIRST_EN
        s = w >> (8 * (3 - i));
`else
        s = w >> (8 * i);
`endif
        return s[7:0];
    endfunction

    // Reference frame position model for instance a.
    task automatic model_push_a(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.pix = lane_pix(w, i);
            e.sof = (mrow == 0 && mcol == 0);
            e.rl  = (mcol == AW - 1);
            e.fl  = e.rl && (mrow == AH - 1);
            qa.push_back(e);
            if (e.rl) begin
                mcol = 0;
                mrow = e.fl ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
            if (e.fl) break;
        end
    endtask

    task automatic set_vec(input int idx, input logic [31:0] w, input int n,
                           input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] p2, input logic [7:0] p3,
                           input logic [3:0] sof, input logic [3:0] rl, input logic [3:0] fl);
        tbl[idx].word   = w;
        tbl[idx].n      = n;
        tbl[idx].pix[0] = p0;
        tbl[idx].pix[1] = p1;
        tbl[idx].pix[2] = p2;
        tbl[idx].pix[3] = p3;
        tbl[idx].sof    = sof;
        tbl[idx].rl     = rl;
        tbl[idx].fl     = fl;
    endtask

    // Drive one word; returns 1 time unit after the accepting edge.
    task automatic send(input bit to_b, input logic [31:0] w);
        int n = 0;
        if (to_b) begin
            b_in_data  = w;
            b_in_valid = 1'b1;
        end else begin
            a_in_data  = w;
            a_in_valid = 1'b1;
            model_push_a(w);
        end
        @(negedge clock);
        while ((to_b ? b_upstream_stall : a_upstream_stall) && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("accept_bound", 32'(n < 100), 32'd1);
        @(posedge clock);
        #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("drain_bound", 32'(n < 300), 32'd1);
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic burst(input int nw, input logic [31:0] base);
        gaps      = 0;
        xfers     = 0;
        in_cyc    = 0;
        stall_cyc = 0;
        prev_cyc  = -1;
        track     = 1'b1;
        for (int i = 0; i < nw; i++) send(1'b0, base + 32'(i) * 32'h04040404);
        drain();
        track = 1'b0;
    endtask

    // Scoreboard: every transfer on either side is popped and compared.
    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (track && a_in_valid) begin
            in_cyc++;
            if (a_upstream_stall) stall_cyc++;
        end
        if (!reset && a_out_valid && !a_downstream_stall) begin
            if (qa.size() == 0) begin
                check("a_unexpected_pixel", 32'(a_out_pixel), 32'hFFFF_FFFF);
            end else begin
                e = qa.pop_front();
                check("a_pixel_flags",
                      32'({a_out_pixel, a_out_sof, a_out_row_last, a_out_frame_last}), 32'(e));
            end
            if (track) begin
                if (prev_cyc >= 0 && cyc != prev_cyc + 1) gaps++;
                prev_cyc = cyc;
                xfers++;
            end
        end
        if (!reset && b_out_valid && !b_downstream_stall) begin
            if (qb.size() == 0) begin
                check("b_unexpected_pixel", 32'(b_out_pixel), 32'hFFFF_FFFF);
            end else begin
                e = qb.pop_front();
                check("b_pixel_flags",
                      32'({b_out_pixel, b_out_sof, b_out_row_last, b_out_frame_last}), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 3x2 frame vectors: bit j of sof/rl/fl belongs to the j-th emitted pixel.
`ifdef IMG_UNPACK_MSB_FIRST_EN
        set_vec(0, 32'h01020304, 4, 8'h01, 8'h02, 8'h03, 8'h04, 4'b0001, 4'b0100, 4'b0000);
        set_vec(1, 32'h05060708, 2, 8'h05, 8'h06, 8'h00, 8'h00, 4'b0000, 4'b0010, 4'b0010);
        set_vec(2, 32'h090A0B0C, 4, 8'h09, 8'h0A, 8'h0B, 8'h0C, 4'b0001, 4'b0100, 4'b0000);
`else
        set_vec(0, 32'h04030201, 4, 8'h01, 8'h02, 8'h03, 8'h04, 4'b0001, 4'b0100, 4'b0000);
        set_vec(1, 32'h08070605, 2, 8'h05, 8'h06, 8'h00, 8'h00, 4'b0000, 4'b0010, 4'b0010);
        set_vec(2, 32'h0C0B0A09, 4, 8'h09, 8'h0A, 8'h0B, 8'h0C, 4'b0001, 4'b0100, 4'b0000);
`endif

        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_pixel", 32'(a_out_pixel), 32'd0);
        check("rst_flags", 32'({a_out_sof, a_out_row_last, a_out_frame_last}), 32'd0);
        check("rst_upstream_stall", 32'(a_upstream_stall), 32'd0);
        check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        @(posedge clock);
        #1;

        // Single word, no stalls: four pixels back to back, sof on the first only.
        burst(1, 32'h44332211);
        check("single_word_xfers", 32'(xfers), 32'd4);
        check("single_word_gaps", 32'(gaps), 32'd0);

        // Frame boundaries on the 3x2 instance, including partial last word.
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                exp_t e;
                e.pix = tbl[i].pix[j];
                e.sof = tbl[i].sof[j];
                e.rl  = tbl[i].rl[j];
                e.fl  = tbl[i].fl[j];
                qb.push_back(e);
            end
            send(1'b1, tbl[i].word);
        end
        drain();
        check("b_idle_after_frame", 32'(b_out_valid), 32'd0);

        // Downstream stall for 5 cycles holding the second pixel.
        send(1'b0, 32'h44332211);
        @(posedge clock);
        @(posedge clock);
        #1;
        a_downstream_stall = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check("stall_hold_pixel", 32'(a_out_pixel), 32'(lane_pix(32'h44332211, 1)));
            check("stall_hold_valid", 32'(a_out_valid), 32'd1);
            check("stall_upstream", 32'(a_upstream_stall), 32'd1);
        end
        @(posedge clock);
        #1;
        a_downstream_stall = 1'b0;
        drain();

        // Eight back-to-back words: 32 pixels, no bubbles, upstream stalled 3 of 4 cycles.
        burst(8, 32'h13121110);
        check("burst_xfers", 32'(xfers), 32'd32);
        check("burst_gaps", 32'(gaps), 32'd0);
        check("burst_in_cycles", 32'(in_cyc), 32'd29);
        check("burst_stall_cycles", 32'(stall_cyc), 32'd21);

        // Reset after two pixels of a word.
        send(1'b0, 32'hDDCCBBAA);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        qa.delete();
        qb.delete();
        mrow = 0;
        mcol = 0;
        @(negedge clock);
        check("post_rst_out_valid", 32'(a_out_valid), 32'd0);
        check("post_rst_upstream", 32'(a_upstream_stall), 32'd0);
        @(posedge clock);
        #1;
        send(1'b0, 32'h55667788);
        drain();

        check("final_qa_empty", 32'(qa.size()), 32'd0);
        check("final_qb_empty", 32'(qb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
